// File: rtl/ram_access_arbiter.sv
// ram_access_arbiter: shares the single-port data RAM between the CPU memory stage and a host/debug port.
module ram_access_arbiter #(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 16,
    parameter int STARVE_LIMIT = 4,
    parameter int READ_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_gnt,
    output logic              host_rvalid,
    output logic [DATA_W-1:0] host_rdata,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_wren,
    input  logic [DATA_W-1:0] ram_q
);
    logic [3:0]              wait_cnt;
    logic [READ_LATENCY-1:0] rd_pipe;
    logic [ADDR_W-1:0]       addr_q;
    logic [DATA_W-1:0]       data_q;
    logic                    cpu_go, host_go, forced, cpu_gnt;

    assign cpu_rdata = ram_q;

    // Requests are masked while reset is held so every output is quiet immediately.
    always_comb begin
        cpu_go      = cpu_req & ~reset;
        host_go     = host_req & ~reset;
        forced      = cpu_go & host_go & (wait_cnt == 4'(STARVE_LIMIT));
        host_gnt    = host_go & (~cpu_go | forced);
        cpu_gnt     = cpu_go & ~host_gnt;
        cpu_stall   = forced;
        ram_address = host_gnt ? host_addr : cpu_gnt ? cpu_addr : addr_q;
        ram_data    = host_gnt ? host_wdata : cpu_gnt ? cpu_wdata : data_q;
        ram_wren    = host_gnt ? host_we : cpu_gnt & cpu_we;
        host_rvalid = rd_pipe[READ_LATENCY-1];
        host_rdata  = host_rvalid ? ram_q : '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt <= '0;
            rd_pipe  <= '0;
            addr_q   <= '0;
            data_q   <= '0;
        end else begin
            wait_cnt <= (!host_req || host_gnt) ? 4'd0 :
                        (wait_cnt == 4'(STARVE_LIMIT)) ? wait_cnt : wait_cnt + 4'd1;
            rd_pipe  <= (rd_pipe << 1) | READ_LATENCY'(host_gnt & ~host_we);
            if (host_gnt || cpu_gnt) begin
                addr_q <= ram_address;
                data_q <= ram_data;
            end
        end
    end
endmodule

// File: tb/tb_ram_access_arbiter.sv
// tb_ram_access_arbiter: directed checks of the RAM arbiter against a behavioural single-port RAM.
module tb_ram_access_arbiter;
    logic        clk = 0, reset = 1;
    logic        cpu_req = 0, cpu_we = 0, host_req = 0, host_we = 0;
    logic [15:0] cpu_addr = 0, cpu_wdata = 0, host_addr = 0, host_wdata = 0;
    logic [15:0] cpu_rdata, host_rdata, ram_address, ram_data, ram_q;
    logic        cpu_stall, host_gnt, host_rvalid, ram_wren;
    logic [15:0] mem [0:65535];
    int          errors = 0, checks = 0;

    ram_access_arbiter dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
        .ram_address(ram_address), .ram_data(ram_data), .ram_wren(ram_wren), .ram_q(ram_q)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_wren) mem[ram_address] <= ram_data;
        ram_q <= mem[ram_address];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic cr, input logic cw, input logic [15:0] ca, input logic [15:0] cd,
                         input logic hr, input logic hw, input logic [15:0] ha, input logic [15:0] hd);
        cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
        host_req = hr; host_we = hw; host_addr = ha; host_wdata = hd;
        #1;
    endtask

    initial begin
        drive(1, 1, 16'h0033, 16'h7777, 1, 1, 16'h0044, 16'h8888);
        check("rst_wren", ram_wren, 0);
        check("rst_gnt", host_gnt, 0);
        check("rst_stall", cpu_stall, 0);
        check("rst_addr", ram_address, 0);
        check("rst_data", ram_data, 0);
        check("rst_rvalid", host_rvalid, 0);
        check("rst_rdata", host_rdata, 0);
        tick();
        reset = 0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        // CPU store then load
        drive(1, 1, 16'h0010, 16'hBEEF, 0, 0, 0, 0);
        check("cpu_st_addr", ram_address, 16'h0010);
        check("cpu_st_data", ram_data, 16'hBEEF);
        check("cpu_st_wren", ram_wren, 1);
        check("cpu_st_gnt", host_gnt, 0);
        tick();
        drive(1, 0, 16'h0010, 16'h0000, 0, 0, 0, 0);
        check("cpu_ld_wren", ram_wren, 0);
        check("cpu_ld_stall", cpu_stall, 0);
        tick();
        drive(0, 0, 16'h0055, 16'h9999, 0, 0, 0, 0);
        check("cpu_rdata", cpu_rdata, 16'hBEEF);
        check("idle_hold_addr", ram_address, 16'h0010);
        check("idle_wren", ram_wren, 0);
        tick();
        // host write then read
        drive(0, 0, 0, 0, 1, 1, 16'h0020, 16'h1234);
        check("h_wr_gnt", host_gnt, 1);
        check("h_wr_addr", ram_address, 16'h0020);
        check("h_wr_wren", ram_wren, 1);
        tick();
        drive(0, 0, 0, 0, 1, 0, 16'h0020, 0);
        check("h_rd_gnt", host_gnt, 1);
        check("h_wr_no_rvalid", host_rvalid, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        check("h_rvalid", host_rvalid, 1);
        check("h_rdata", host_rdata, 16'h1234);
        tick();
        check("h_rvalid_off", host_rvalid, 0);
        check("h_rdata_off", host_rdata, 0);
        // continuous conflict: period of 5 with forced host grant on the fifth cycle
        drive(1, 0, 16'h0010, 0, 1, 0, 16'h0020, 0);
        for (int c = 0; c < 12; c++) begin
            check($sformatf("cf_gnt%0d", c), host_gnt, (c % 5) == 4);
            check($sformatf("cf_stall%0d", c), cpu_stall, (c % 5) == 4);
            check($sformatf("cf_addr%0d", c), ram_address, ((c % 5) == 4) ? 16'h0020 : 16'h0010);
            check($sformatf("cf_rvalid%0d", c), host_rvalid, c > 0 && (c % 5) == 0);
            if (c > 0 && (c % 5) == 0) check($sformatf("cf_rdata%0d", c), host_rdata, 16'h1234);
            tick();
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        // host drops its request: the wait count restarts
        drive(1, 0, 16'h0010, 0, 1, 0, 16'h0020, 0);
        for (int k = 0; k < 2; k++) begin
            check($sformatf("drop_pre%0d", k), host_gnt, 0);
            tick();
        end
        drive(1, 0, 16'h0010, 0, 0, 0, 16'h0020, 0);
        check("drop_gap", host_gnt, 0);
        tick();
        drive(1, 0, 16'h0010, 0, 1, 0, 16'h0020, 0);
        for (int k = 0; k < 5; k++) begin
            check($sformatf("drop_gnt%0d", k), host_gnt, k == 4);
            check($sformatf("drop_stall%0d", k), cpu_stall, k == 4);
            tick();
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        // back-to-back host reads
        for (int k = 0; k < 3; k++) begin
            drive(0, 0, 0, 0, 1, 1, 16'(k + 1), 16'(16'h00A1 + k));
            check($sformatf("pre_gnt%0d", k), host_gnt, 1);
            tick();
        end
        for (int k = 0; k < 5; k++) begin
            drive(0, 0, 0, 0, k < 3, 0, 16'(k + 1), 0);
            check($sformatf("b2b_rvalid%0d", k), host_rvalid, k >= 1 && k <= 3);
            check($sformatf("b2b_rdata%0d", k), host_rdata, (k >= 1 && k <= 3) ? 16'(16'h00A0 + k) : 16'h0);
            tick();
        end
        // reset mid-cycle while a host read is being granted
        drive(0, 0, 0, 0, 1, 0, 16'h0020, 0);
        check("mr_gnt", host_gnt, 1);
        #2;
        reset = 1;
        cpu_req = 1; cpu_we = 1;
        #1;
        check("mr_wren", ram_wren, 0);
        check("mr_stall", cpu_stall, 0);
        check("mr_gnt_off", host_gnt, 0);
        check("mr_addr", ram_address, 0);
        tick();
        check("mr_rvalid", host_rvalid, 0);
        reset = 0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        check("mr_rvalid2", host_rvalid, 0);
        // reset while rvalid is already high drops it immediately
        drive(0, 0, 0, 0, 1, 0, 16'h0020, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        check("rv_pre", host_rvalid, 1);
        reset = 1;
        #1;
        check("rv_drop", host_rvalid, 0);
        check("rv_rdata", host_rdata, 0);
        tick();
        reset = 0;
        drive(1, 1, 16'h0077, 16'h4242, 0, 0, 0, 0);
        check("post_rst_wren", ram_wren, 1);
        check("post_rst_addr", ram_address, 16'h0077);
        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ram_access_arbiter.md
Name: ram_access_arbiter

Overview:
- Shares the single-port data RAM between two requesters: the CPU memory stage and a host/debug port used for loading data and inspecting memory.
- Default priority goes to the CPU.
- A starvation counter forces a host grant after a bounded wait. On that cycle the pipeline is frozen through cpu_stall.
- Sits between the ExecuteMemory register outputs and the RAM instance. It replaces the direct srcA/srcB/wren wiring to the RAM.

Parameters:
- ADDR_W, 16, RAM address width.
- DATA_W, 16, RAM data width.
- STARVE_LIMIT, 4, number of consecutive denied host cycles before the host is forced through. Legal range 1..15.
- READ_LATENCY, 1, RAM read latency in cycles. Legal range 1..2.

Ports:
- clk  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-high reset.
- cpu_req  in  1  memory stage performs a RAM access this cycle (load or store).
- cpu_we  in  1  1 = store, 0 = load.
- cpu_addr  in  ADDR_W  CPU access address.
- cpu_wdata  in  DATA_W  CPU store data.
- cpu_rdata  out  DATA_W  CPU load data (ram_q passthrough).
- cpu_stall  out  1  freeze PC, all pipeline registers and the memory stage this cycle.
- host_req  in  1  host access request. Held with stable fields until host_gnt.
- host_we  in  1  host write enable.
- host_addr  in  ADDR_W  host address.
- host_wdata  in  DATA_W  host write data.
- host_gnt  out  1  host access accepted this cycle.
- host_rvalid  out  1  host_rdata valid.
- host_rdata  out  DATA_W  host read data.
- ram_address  out  ADDR_W  to RAM address.
- ram_data  out  DATA_W  to RAM data.
- ram_wren  out  1  to RAM write enable.
- ram_q  in  DATA_W  from RAM.

Behaviour:
- Grant decision is combinational from the request inputs and the registered wait counter (wait_cnt, 4 bits). Only one grant per cycle.
- Neither request:
  - ram_wren=0, host_gnt=0, cpu_stall=0.
  - ram_address/ram_data hold their last driven values; use a registered mux select, no X.
- cpu_req only: CPU granted.
  - ram_address=cpu_addr, ram_data=cpu_wdata, ram_wren=cpu_we, cpu_stall=0.
- host_req only: host granted.
  - ram_* driven from host fields, host_gnt=1, cpu_stall=0.
- Both requesting, wait_cnt < STARVE_LIMIT:
  - CPU granted, host_gnt=0.
  - wait_cnt increments at the edge, saturating at STARVE_LIMIT.
- Both requesting, wait_cnt == STARVE_LIMIT:
  - Host granted, host_gnt=1, cpu_stall=1.
  - The CPU holds cpu_req and its fields (pipeline frozen) and is granted on the next cycle.
- wait_cnt clears to 0 on any host grant, and on any cycle with host_req=0.
- Stall policy:
  - cpu_stall is asserted only on forced-host cycles.
  - Never two consecutive stall cycles: after a forced grant wait_cnt=0, so the CPU wins the next conflict.
- Writes: a granted write commits at the rising edge of the grant cycle.
- Host reads:
  - Each granted host read pushes a tag into a READ_LATENCY-deep shift register.
  - host_rvalid=1 exactly READ_LATENCY cycles after the grant cycle, with host_rdata=ram_q.
  - Host writes produce no rvalid.
  - Back-to-back host reads yield back-to-back rvalid.
- CPU reads:
  - cpu_rdata=ram_q unconditionally; pipeline timing is unchanged from direct RAM wiring.
  - A host grant on cycle N does not disturb a CPU load granted on N-1 when READ_LATENCY=1, because q reflects the N-1 address at N.
- Reset (asynchronous, any time, including mid-read):
  - wait_cnt=0 and the rvalid pipeline is cleared, so pending host reads are dropped.
  - Mux select resets to CPU.
  - Outputs during and after reset: ram_address=0, ram_data=0, ram_wren=0, host_gnt=0, host_rvalid=0, host_rdata=0, cpu_stall=0.
  - First grant is possible on the first rising edge after reset deasserts.

Test Plan:
- Reset: assert reset mid-cycle with a host read pending → host_rvalid stays 0; ram_wren=0, cpu_stall=0 immediately (asynchronous).
- CPU only: cpu_we=1, addr=0x0010, data=0xBEEF; then a CPU load from 0x0010 → cpu_rdata=0xBEEF one cycle after the load grant; host_gnt never 1.
- Host only: host write 0x0020←0x1234, then host read 0x0020 → host_gnt=1 on each request cycle; host_rvalid=1 with host_rdata=0x1234 exactly 1 cycle after the read grant.
- Conflict, STARVE_LIMIT=4: cpu_req and host_req held continuously →
  - CPU granted cycles 0–3, wait_cnt 1,2,3,4.
  - Cycle 4: host_gnt=1, cpu_stall=1.
  - Cycle 5: CPU granted, wait_cnt=0.
  - Pattern repeats with a period of 5.
- Host drop: host_req high 2 conflicting cycles, low 1 cycle, high again → wait_cnt returns to 0; forced grant occurs only after 4 further conflict cycles.
- Back-to-back host reads of 0x0001, 0x0002, 0x0003 (preloaded 0xA1, 0xA2, 0xA3) with no CPU traffic → three consecutive host_rvalid pulses carrying 0xA1, 0xA2, 0xA3 in order.
